// File: rtl/proc_ctrl_fsm.sv
// proc_ctrl_fsm: multi-cycle control unit for the 16-bit register-file processor.
// Steps through timesteps T0..T3 and decodes the 9-bit instruction (IIIXXXYYY)
// into register load enables, bus-drive selects and ALU controls. It also
// counts retired instructions.
module proc_ctrl_fsm #(
  parameter int NREG  = 8,
  parameter int CNT_W = 16
) (
  input  logic             i_clock,
  input  logic             i_resetn,
  input  logic             i_run,
  input  logic [8:0]       i_ir,
  input  logic             i_gnz,
  output logic             o_irin,
  output logic [NREG-1:0]  o_rin,
  output logic [NREG-1:0]  o_rout,
  output logic             o_dinout,
  output logic             o_gout,
  output logic             o_ain,
  output logic             o_gin,
  output logic             o_addsub,
  output logic             o_done,
  output logic [CNT_W-1:0] o_retcnt
);

  // Opcode encodings; 101..111 all fall through to NOP handling
  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MVNZ = 3'b100;

  localparam logic [NREG-1:0] SEL_LSB = NREG'(1);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_retCnt;

  logic [2:0]      w_opcode;
  logic [NREG-1:0] w_xSel;
  logic [NREG-1:0] w_ySel;
  logic            w_isArith;

  logic            w_irin;
  logic [NREG-1:0] w_rin;
  logic [NREG-1:0] w_rout;
  logic            w_dinout;
  logic            w_gout;
  logic            w_ain;
  logic            w_gin;
  logic            w_addsub;
  logic            w_done;

  // Instruction field decode: X is the destination, Y the source operand
  assign w_opcode  = i_ir[8:6];
  assign w_xSel    = SEL_LSB << i_ir[5:3];
  assign w_ySel    = SEL_LSB << i_ir[2:0];
  assign w_isArith = (w_opcode == OP_ADD) || (w_opcode == OP_SUB);

  // Control decode from the current timestep and the instruction; only one
  // bus source is ever selected in a given timestep
  always_comb begin
    w_irin   = 1'b0;
    w_rin    = '0;
    w_rout   = '0;
    w_dinout = 1'b0;
    w_gout   = 1'b0;
    w_ain    = 1'b0;
    w_gin    = 1'b0;
    w_addsub = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      T0: begin
        w_irin = i_run;
      end
      T1: begin
        case (w_opcode)
          OP_MV: begin
            w_rout = w_ySel;
            w_rin  = w_xSel;
            w_done = 1'b1;
          end
          OP_MVI: begin
            w_dinout = 1'b1;
            w_rin    = w_xSel;
            w_done   = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            w_rout = w_xSel;
            w_ain  = 1'b1;
          end
          OP_MVNZ: begin
            w_done = 1'b1;
            if (i_gnz) begin
              w_rout = w_ySel;
              w_rin  = w_xSel;
            end
          end
          default: begin
            w_done = 1'b1;
          end
        endcase
      end
      T2: begin
        if (w_isArith) begin
          w_rout   = w_ySel;
          w_gin    = 1'b1;
          w_addsub = (w_opcode == OP_SUB);
        end
      end
      T3: begin
        if (w_isArith) begin
          w_gout = 1'b1;
          w_rin  = w_xSel;
        end
        w_done = 1'b1;
      end
      default: begin
        w_irin = 1'b0;
      end
    endcase
  end

  // Timestep sequencing and the retired-instruction counter; reset aborts
  // any instruction in flight and clears the count
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state  <= T0;
      r_retCnt <= '0;
    end else begin
      r_retCnt <= r_retCnt + CNT_W'(w_done);
      case (r_state)
        T0:      r_state <= i_run ? T1 : T0;
        T1:      r_state <= w_isArith ? T2 : T0;
        T2:      r_state <= T3;
        T3:      r_state <= T0;
        default: r_state <= T0;
      endcase
    end
  end

  // Reset forces every control output low; IRin would otherwise follow Run in T0
  assign o_irin   = w_irin & i_resetn;
  assign o_rin    = w_rin & {NREG{i_resetn}};
  assign o_rout   = w_rout & {NREG{i_resetn}};
  assign o_dinout = w_dinout & i_resetn;
  assign o_gout   = w_gout & i_resetn;
  assign o_ain    = w_ain & i_resetn;
  assign o_gin    = w_gin & i_resetn;
  assign o_addsub = w_addsub & i_resetn;
  assign o_done   = w_done & i_resetn;
  assign o_retcnt = r_retCnt;

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// tb_proc_ctrl_fsm: table-driven directed test of proc_ctrl_fsm plus
// hand-written sequences for reset and mid-instruction abort.
module tb_proc_ctrl_fsm;

  logic        clock;
  logic        resetn;
  logic        run;
  logic [8:0]  ir;
  logic        gnz;
  logic        irin;
  logic [7:0]  rin;
  logic [7:0]  rout;
  logic        dinout;
  logic        gout;
  logic        ain;
  logic        gin;
  logic        addsub;
  logic        done;
  logic [15:0] retcnt;

  int checkCount = 0;
  int errorCount = 0;

  typedef struct {
    string       name;
    logic        run;
    logic [8:0]  ir;
    logic        gnz;
    logic [38:0] expOut;
  } vec_t;

  vec_t vecs[$];

  proc_ctrl_fsm #(.NREG(8), .CNT_W(16)) dut (
    .i_clock  (clock),
    .i_resetn (resetn),
    .i_run    (run),
    .i_ir     (ir),
    .i_gnz    (gnz),
    .o_irin   (irin),
    .o_rin    (rin),
    .o_rout   (rout),
    .o_dinout (dinout),
    .o_gout   (gout),
    .o_ain    (ain),
    .o_gin    (gin),
    .o_addsub (addsub),
    .o_done   (done),
    .o_retcnt (retcnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pack an expected output set: irin, rin, rout, dinout, gout, ain, gin, addsub, done, retcnt
  function automatic logic [38:0] mk(input logic eIrin, input logic [7:0] eRin,
                                     input logic [7:0] eRout, input logic eDin,
                                     input logic eGout, input logic eAin, input logic eGin,
                                     input logic eSub, input logic eDone, input logic [15:0] eCnt);
    return {eIrin, eRin, eRout, eDin, eGout, eAin, eGin, eSub, eDone, eCnt};
  endfunction

  task automatic addVec(input string n, input logic r, input logic [8:0] i,
                        input logic g, input logic [38:0] e);
    vec_t v;
    v.name   = n;
    v.run    = r;
    v.ir     = i;
    v.gnz    = g;
    v.expOut = e;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string n, input logic [38:0] expOut);
    logic [38:0] act;
    act = {irin, rin, rout, dinout, gout, ain, gin, addsub, done, retcnt};
    checkCount++;
    if (act !== expOut) begin
      errorCount++;
      $display("[TB] FAIL %s: got irin=%b rin=%h rout=%h din=%b gout=%b ain=%b gin=%b sub=%b done=%b cnt=%0d, want irin=%b rin=%h rout=%h din=%b gout=%b ain=%b gin=%b sub=%b done=%b cnt=%0d",
               n, act[38], act[37:30], act[29:22], act[21], act[20], act[19], act[18], act[17], act[16], act[15:0],
               expOut[38], expOut[37:30], expOut[29:22], expOut[21], expOut[20], expOut[19], expOut[18], expOut[17], expOut[16], expOut[15:0]);
    end
    checkCount++;
    if ($countones({rout, dinout, gout}) > 1) begin
      errorCount++;
      $display("[TB] FAIL %s_busOneHot: got rout=%h din=%b gout=%b, want at most one bus source",
               n, rout, dinout, gout);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [8:0] i, input logic g);
    run = r;
    ir  = i;
    gnz = g;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  localparam logic [8:0] MVI_R3   = 9'b001_011_000;
  localparam logic [8:0] SUB_R1R6 = 9'b011_001_110;
  localparam logic [8:0] MVNZ_R0R5 = 9'b100_000_101;
  localparam logic [8:0] ADD_R2R2 = 9'b010_010_010;
  localparam logic [8:0] MV_R7R2  = 9'b000_111_010;
  localparam logic [8:0] NOP_101  = 9'b101_000_000;
  localparam logic [8:0] ADD_R1R2 = 9'b010_001_010;
  localparam logic [8:0] MVI_R5   = 9'b001_101_000;

  // Main directed test: reset, vector table, then mid-instruction reset sequence
  initial begin
    addVec("mvi_t0",    1, MVI_R3,    0, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    addVec("mvi_t1",    0, MVI_R3,    0, mk(0, 8'h08, 8'h00, 1, 0, 0, 0, 0, 1, 0));
    addVec("idle_t0",   0, SUB_R1R6,  0, mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1));
    addVec("sub_t0",    1, SUB_R1R6,  0, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1));
    addVec("sub_t1",    0, SUB_R1R6,  0, mk(0, 8'h00, 8'h02, 0, 0, 1, 0, 0, 0, 1));
    addVec("sub_t2",    1, SUB_R1R6,  0, mk(0, 8'h00, 8'h40, 0, 0, 0, 1, 1, 0, 1));
    addVec("sub_t3",    1, SUB_R1R6,  0, mk(0, 8'h02, 8'h00, 0, 1, 0, 0, 0, 1, 1));
    addVec("mvnz0_t0",  1, MVNZ_R0R5, 0, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2));
    addVec("mvnz0_t1",  0, MVNZ_R0R5, 0, mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 2));
    addVec("mvnz1_t0",  1, MVNZ_R0R5, 1, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 3));
    addVec("mvnz1_t1",  0, MVNZ_R0R5, 1, mk(0, 8'h01, 8'h20, 0, 0, 0, 0, 0, 1, 3));
    addVec("add22_t0",  1, ADD_R2R2,  0, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 4));
    addVec("add22_t1",  0, ADD_R2R2,  0, mk(0, 8'h00, 8'h04, 0, 0, 1, 0, 0, 0, 4));
    addVec("add22_t2",  0, ADD_R2R2,  0, mk(0, 8'h00, 8'h04, 0, 0, 0, 1, 0, 0, 4));
    addVec("add22_t3",  1, ADD_R2R2,  0, mk(0, 8'h04, 8'h00, 0, 1, 0, 0, 0, 1, 4));
    addVec("mv72_t0",   1, MV_R7R2,   0, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 5));
    addVec("mv72_t1",   0, MV_R7R2,   0, mk(0, 8'h80, 8'h04, 0, 0, 0, 0, 0, 1, 5));
    addVec("idle2_t0",  0, MV_R7R2,   0, mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 6));
    addVec("nop_t0",    1, NOP_101,   0, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 6));
    addVec("nop_t1",    0, NOP_101,   0, mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 6));
    addVec("idle3_t0",  0, NOP_101,   0, mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 7));

    resetn = 1'b0;
    run    = 1'b1;
    ir     = MVI_R3;
    gnz    = 1'b0;
    #3;
    checkOutput("reset_async", mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    nextCycle();
    checkOutput("reset_held", mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    resetn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].run, vecs[i].ir, vecs[i].gnz);
      checkOutput(vecs[i].name, vecs[i].expOut);
      nextCycle();
    end

    applyStimulus(1, ADD_R1R2, 0);
    checkOutput("abort_t0", mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 7));
    nextCycle();
    applyStimulus(0, ADD_R1R2, 0);
    checkOutput("abort_t1", mk(0, 8'h00, 8'h02, 0, 0, 1, 0, 0, 0, 7));
    nextCycle();
    applyStimulus(0, ADD_R1R2, 0);
    checkOutput("abort_t2", mk(0, 8'h00, 8'h04, 0, 0, 0, 1, 0, 0, 7));
    resetn = 1'b0;
    #1;
    checkOutput("abort_rst", mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    run = 1'b1;
    nextCycle();
    checkOutput("abort_rst_hold", mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    resetn = 1'b1;
    applyStimulus(0, ADD_R1R2, 0);
    checkOutput("abort_release", mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    nextCycle();
    checkOutput("abort_wait", mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(1, MVI_R5, 0);
    checkOutput("post_mvi_t0", mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    nextCycle();
    applyStimulus(0, MVI_R5, 0);
    checkOutput("post_mvi_t1", mk(0, 8'h20, 8'h00, 1, 0, 0, 0, 0, 1, 0));
    nextCycle();
    checkOutput("post_mvi_idle", mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1));

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
